// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet-granular AXI-Stream arbiter.
// Holds the arbiter FSM encoding, default bus widths and stats counter width.
package axis_arb_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int KEEP_W_DEF = DATA_W_DEF / 8;
  localparam int STATS_W    = 16;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  // Circular increment of a source index over n ports.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    logic [IDX_W:0] nxt;
    nxt = {1'b0, idx} + {{IDX_W{1'b0}}, 1'b1};
    if (int'(nxt) >= n) return '0;
    return nxt[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
// Zero latency; no state, no backpressure of its own.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] gnt_oh_o,
  output logic [2:0]   gnt_idx_o,
  output logic         gnt_vld_o
);

  // First pass only looks at indices >= ptr; second pass covers the wrap.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld_o && req_i[i] && (3'(i) >= ptr_i)) begin
        gnt_vld_o   = 1'b1;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = 3'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_vld_o && req_i[i]) begin
        gnt_vld_o   = 1'b1;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin AXI-Stream merge; 1 ARB cycle per packet, data path is combinational.
// Backpressure: only the granted source sees m_tready; AXIS_ARB_STATS_EN adds per-source packet counters.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int   NUM_IN = 4,
  parameter int   DATA_W = DATA_W_DEF,
  localparam int  KEEP_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     resent,
  input  logic [NUM_IN*DATA_W-1:0] s_tdata,
  input  logic [NUM_IN*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_IN-1:0]        s_tvalid,
  input  logic [NUM_IN-1:0]        s_tlast,
  output logic [NUM_IN-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [2:0]               grant_id,
  output logic                     busy
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [NUM_IN*STATS_W-1:0] pkt_stats
`endif
);

  arb_state_e          state_q;
  logic [2:0]          grant_q;
  logic [NUM_IN-1:0]   grant_oh_q;
  logic [2:0]          rr_ptr_q;
  logic                busy_q;

  logic [NUM_IN-1:0]   arb_oh;
  logic [2:0]          arb_idx;
  logic                arb_vld;
  logic                xfer;
  logic                pkt_end;

  rr_arbiter #(.N(NUM_IN)) u_rr_arbiter (
    .req_i     (s_tvalid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // Qualifying with resent keeps the sink and sources quiet during the reset cycle itself.
  assign xfer = (state_q == ST_XFER) && !resent;

  always_comb begin
    m_tdata = '0;
    m_tkeep = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_oh_q[i]) begin
        m_tdata = m_tdata | s_tdata[i*DATA_W +: DATA_W];
        m_tkeep = m_tkeep | s_tkeep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  assign m_tvalid = xfer && |(s_tvalid & grant_oh_q);
  assign m_tlast  = |(s_tlast & grant_oh_q);
  assign s_tready = (xfer && m_tready) ? grant_oh_q : '0;
  assign pkt_end  = m_tvalid && m_tready && m_tlast;
  assign grant_id = grant_q;
  assign busy     = busy_q;

  always_ff @(posedge clk) begin
    if (resent) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|s_tvalid) state_q <= ST_ARB;
        end
        ST_ARB: begin
          if (arb_vld) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_oh;
            busy_q     <= 1'b1;
            state_q    <= ST_XFER;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (pkt_end) begin
            rr_ptr_q <= wrap_inc(grant_q, NUM_IN);
            busy_q   <= 1'b0;
            state_q  <= (|s_tvalid) ? ST_ARB : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [STATS_W-1:0] stats_q [NUM_IN];
  logic [STATS_W-1:0] stats_d [NUM_IN];

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      stats_d[i] = stats_q[i] + ((pkt_end && grant_oh_q[i]) ? STATS_W'(1) : STATS_W'(0));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN; i++) begin
      stats_q[i] <= resent ? '0 : stats_d[i];
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_stats
    assign pkt_stats[g*STATS_W +: STATS_W] = stats_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed cycle vectors for axis_packet_arbiter: round-robin order, stalls, backpressure, reset, stats.
module tb_axis_packet_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              resent = 1'b1;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*KW-1:0]   s_tkeep = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready = 1'b1;
  logic [2:0]        grant_id;
  logic              busy;
`ifdef AXIS_ARB_STATS_EN
  logic [N*16-1:0]   pkt_stats;
`endif

  always #5 clk = ~clk;

  axis_packet_arbiter #(.NUM_IN(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .resent   (resent),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_stats(pkt_stats)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       mrdy;
    logic [7:0] beat;
    logic       mvld;
    logic       mlast;
    logic       busy;
    logic [2:0] gid;
    logic [3:0] srdy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic [3:0] lst,
                              input logic mrdy, input logic [7:0] beat, input logic mvld,
                              input logic mlast, input logic bsy, input logic [2:0] gid,
                              input logic [3:0] srdy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lst = lst; v.mrdy = mrdy; v.beat = beat;
    v.mvld = mvld; v.mlast = mlast; v.busy = bsy; v.gid = gid; v.srdy = srdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each source drives {source index, beat number, 16'hC0DE} and keep = 4'hF ^ index.
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] exp_dat;
    logic [3:0]  exp_keep;
    @(negedge clk);
    resent   = v.rst;
    s_tvalid = v.vld;
    s_tlast  = v.lst;
    m_tready = v.mrdy;
    for (int i = 0; i < N; i++) begin
      s_tdata[i*DW +: DW] = {i[7:0], v.beat, 16'hC0DE};
      s_tkeep[i*KW +: KW] = 4'hF ^ i[3:0];
    end
    #2;
    chk({tag, " m_tvalid"}, 32'(m_tvalid), 32'(v.mvld));
    chk({tag, " busy"},     32'(busy),     32'(v.busy));
    chk({tag, " grant_id"}, 32'(grant_id), 32'(v.gid));
    chk({tag, " s_tready"}, 32'(s_tready), 32'(v.srdy));
    if (v.mvld) begin
      exp_dat  = {5'd0, v.gid, v.beat, 16'hC0DE};
      exp_keep = 4'hF ^ {1'b0, v.gid};
      chk({tag, " m_tlast"}, 32'(m_tlast), 32'(v.mlast));
      chk({tag, " m_tdata"}, m_tdata, exp_dat);
      chk({tag, " m_tkeep"}, 32'(m_tkeep), 32'(exp_keep));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];

    // All four sources with 2-beat packets; source 0 has a second packet queued.
    tab.push_back(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0));
    tab.push_back(mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0));
    tab.push_back(mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0));
    tab.push_back(mk(0, 4'hF, 4'h0, 1, 0, 1, 0, 1, 0, 4'h1));
    tab.push_back(mk(0, 4'hF, 4'h1, 1, 1, 1, 1, 1, 0, 4'h1));
    tab.push_back(mk(0, 4'hF, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0));
    tab.push_back(mk(0, 4'hF, 4'h0, 1, 0, 1, 0, 1, 1, 4'h2));
    tab.push_back(mk(0, 4'hF, 4'h2, 1, 1, 1, 1, 1, 1, 4'h2));
    tab.push_back(mk(0, 4'hD, 4'h0, 1, 0, 0, 0, 0, 1, 4'h0));
    tab.push_back(mk(0, 4'hD, 4'h0, 1, 0, 1, 0, 1, 2, 4'h4));
    tab.push_back(mk(0, 4'hD, 4'h4, 1, 1, 1, 1, 1, 2, 4'h4));
    tab.push_back(mk(0, 4'h9, 4'h0, 1, 0, 0, 0, 0, 2, 4'h0));
    tab.push_back(mk(0, 4'h9, 4'h0, 1, 0, 1, 0, 1, 3, 4'h8));
    tab.push_back(mk(0, 4'h9, 4'h8, 1, 1, 1, 1, 1, 3, 4'h8));
    tab.push_back(mk(0, 4'h1, 4'h0, 1, 0, 0, 0, 0, 3, 4'h0));
    tab.push_back(mk(0, 4'h1, 4'h0, 1, 0, 1, 0, 1, 0, 4'h1));
    tab.push_back(mk(0, 4'h1, 4'h1, 1, 1, 1, 1, 1, 0, 4'h1));
    tab.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0));
    tab.push_back(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0));

    repeat (2) @(posedge clk);
    for (int k = 0; k < tab.size(); k++) run_vec(tab[k], $sformatf("rr%0d", k));

    // Source 2 stalls mid-packet while source 1 waits; grant must hold on 2.
    run_vec(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "st_rst");
    run_vec(mk(0, 4'h4, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "st0");
    run_vec(mk(0, 4'h4, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "st1");
    run_vec(mk(0, 4'h6, 4'h0, 1, 1, 1, 0, 1, 2, 4'h4), "st2");
    run_vec(mk(0, 4'h6, 4'h0, 1, 2, 1, 0, 1, 2, 4'h4), "st3");
    run_vec(mk(0, 4'h2, 4'h0, 1, 3, 0, 0, 1, 2, 4'h4), "st4");
    run_vec(mk(0, 4'h2, 4'h0, 1, 3, 0, 0, 1, 2, 4'h4), "st5");
    run_vec(mk(0, 4'h6, 4'h0, 1, 3, 1, 0, 1, 2, 4'h4), "st6");
    run_vec(mk(0, 4'h6, 4'h0, 1, 4, 1, 0, 1, 2, 4'h4), "st7");
    run_vec(mk(0, 4'h6, 4'h4, 1, 5, 1, 1, 1, 2, 4'h4), "st8");
    run_vec(mk(0, 4'h2, 4'h0, 1, 0, 0, 0, 0, 2, 4'h0), "st9");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 1, 1, 1, 1, 4'h2), "st10");
    run_vec(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h0), "st11");

    // Sink backpressure toggling during a 4-beat packet from source 0.
    run_vec(mk(0, 4'h1, 4'h0, 1, 0, 0, 0, 0, 1, 4'h0), "bp0");
    run_vec(mk(0, 4'h1, 4'h0, 1, 0, 0, 0, 0, 1, 4'h0), "bp1");
    run_vec(mk(0, 4'h1, 4'h0, 1, 0, 1, 0, 1, 0, 4'h1), "bp2");
    run_vec(mk(0, 4'h1, 4'h0, 0, 1, 1, 0, 1, 0, 4'h0), "bp3");
    run_vec(mk(0, 4'h1, 4'h0, 1, 1, 1, 0, 1, 0, 4'h1), "bp4");
    run_vec(mk(0, 4'h1, 4'h0, 0, 2, 1, 0, 1, 0, 4'h0), "bp5");
    run_vec(mk(0, 4'h1, 4'h0, 1, 2, 1, 0, 1, 0, 4'h1), "bp6");
    run_vec(mk(0, 4'h1, 4'h1, 0, 3, 1, 1, 1, 0, 4'h0), "bp7");
    run_vec(mk(0, 4'h1, 4'h1, 1, 3, 1, 1, 1, 0, 4'h1), "bp8");
    run_vec(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "bp9");

    // Reset mid-packet with rr_ptr at 1; afterwards sources 0 and 1 must resolve to 0 first.
    run_vec(mk(0, 4'h4, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "mr0");
    run_vec(mk(0, 4'h4, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "mr1");
    run_vec(mk(0, 4'h4, 4'h0, 1, 1, 1, 0, 1, 2, 4'h4), "mr2");
    run_vec(mk(1, 4'h4, 4'h0, 1, 2, 0, 0, 1, 2, 4'h0), "mr3");
    run_vec(mk(0, 4'h3, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "mr4");
    run_vec(mk(0, 4'h3, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "mr5");
    run_vec(mk(0, 4'h3, 4'h1, 1, 0, 1, 1, 1, 0, 4'h1), "mr6");
    run_vec(mk(0, 4'h2, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "mr7");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 1, 1, 1, 1, 4'h2), "mr8");
    run_vec(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h0), "mr9");

    // Lone source 3 with three single-beat packets back to back.
    run_vec(mk(0, 4'h8, 4'h8, 1, 0, 0, 0, 0, 1, 4'h0), "sb0");
    run_vec(mk(0, 4'h8, 4'h8, 1, 0, 0, 0, 0, 1, 4'h0), "sb1");
    run_vec(mk(0, 4'h8, 4'h8, 1, 0, 1, 1, 1, 3, 4'h8), "sb2");
    run_vec(mk(0, 4'h8, 4'h8, 1, 1, 0, 0, 0, 3, 4'h0), "sb3");
    run_vec(mk(0, 4'h8, 4'h8, 1, 1, 1, 1, 1, 3, 4'h8), "sb4");
    run_vec(mk(0, 4'h8, 4'h8, 1, 2, 0, 0, 0, 3, 4'h0), "sb5");
    run_vec(mk(0, 4'h8, 4'h8, 1, 2, 1, 1, 1, 3, 4'h8), "sb6");
    run_vec(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 3, 4'h0), "sb7");

`ifdef AXIS_ARB_STATS_EN
    // Three packets from source 1, then one from source 0.
    run_vec(mk(1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 3, 4'h0), "ps_rst");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 0, 0, 0, 0, 4'h0), "ps0");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 0, 0, 0, 0, 4'h0), "ps1");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 1, 1, 1, 1, 4'h2), "ps2");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 0, 0, 0, 1, 4'h0), "ps3");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 1, 1, 1, 1, 4'h2), "ps4");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 0, 0, 0, 1, 4'h0), "ps5");
    run_vec(mk(0, 4'h2, 4'h2, 1, 0, 1, 1, 1, 1, 4'h2), "ps6");
    run_vec(mk(0, 4'h1, 4'h1, 1, 0, 0, 0, 0, 1, 4'h0), "ps7");
    run_vec(mk(0, 4'h1, 4'h1, 1, 0, 1, 1, 1, 0, 4'h1), "ps8");
    run_vec(mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0), "ps9");
    chk("pkt_stats src0", 32'(pkt_stats[0 +: 16]),  32'd1);
    chk("pkt_stats src1", 32'(pkt_stats[16 +: 16]), 32'd3);
    chk("pkt_stats src2", 32'(pkt_stats[32 +: 16]), 32'd0);
    chk("pkt_stats src3", 32'(pkt_stats[48 +: 16]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
